// File: rtl/pawc_pkg.sv
// Shared constants for the sample-capture FIFO: register indices, CTRL bits,
// STATUS bit positions and a STATUS word packer.
package pawc_pkg;

    // Register indices as decoded from byte address bits [3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;   // 0x0
    localparam logic [1:0] REG_STATUS = 2'd1;   // 0x4
    localparam logic [1:0] REG_DATA   = 2'd2;   // 0x8
    localparam logic [1:0] REG_OVF    = 2'd3;   // 0xC

    // CTRL bits
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    // STATUS bit positions
    localparam int ST_LEVEL_W   = 11;
    localparam int ST_EMPTY_BIT = 16;
    localparam int ST_FULL_BIT  = 17;
    localparam int ST_OVF_BIT   = 18;
    localparam int ST_UDF_BIT   = 19;

    function automatic logic [31:0] pack_status(
        input logic [ST_LEVEL_W-1:0] level,
        input logic                  empty,
        input logic                  full,
        input logic                  ovf,
        input logic                  udf
    );
        logic [31:0] s;
        s                   = '0;
        s[ST_LEVEL_W-1:0]   = level;
        s[ST_EMPTY_BIT]     = empty;
        s[ST_FULL_BIT]      = full;
        s[ST_OVF_BIT]       = ovf;
        s[ST_UDF_BIT]       = udf;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one combinational read port so the
// oldest word is available in the same cycle the bus access is decoded.
module sync_fifo_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Write port: storage is deliberately not reset
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wb_sample_fifo.sv
// Wishbone classic slave wrapping a sample-capture FIFO with overflow and
// underflow tracking. Bus accesses ack one cycle after start, then always take
// one ack-low cycle before the next access can begin.
module wb_sample_fifo
    import pawc_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int OVF_W = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_rty_o,
    input  logic        smp_valid,
    input  logic [31:0] smp_data
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              r_en;
    logic              r_ovf;
    logic              r_udf;
    logic [OVF_W-1:0]  r_ovf_cnt;
    logic              r_ack;
    logic [31:0]       r_dat;

    logic              w_start;
    logic              w_rd;
    logic              w_wr;
    logic [1:0]        w_reg;
    logic              w_empty;
    logic              w_full;
    logic [AW:0]       w_level;
    logic              w_flush;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [31:0]       w_mem_rdata;
    logic [31:0]       w_rdata;
    logic              w_unused_bits;

    // Counter increment that sticks at all ones
    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + OVF_W'(1);
    endfunction

    // Only full-word accesses on bits [3:2]; the rest of the address and selects are don't-care
    assign w_unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i};

    // An access starts on any strobed cycle that is not itself an ack cycle
    assign w_start = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_rd    = w_start & ~wb_we_i;
    assign w_wr    = w_start &  wb_we_i;
    assign w_reg   = wb_adr_i[3:2];

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_level = r_wr_ptr - r_rd_ptr;

    // A pop at full frees a slot in the same edge, so the push is still accepted
    assign w_flush = w_wr && (w_reg == REG_CTRL) && wb_dat_i[CTRL_FLUSH_BIT];
    assign w_pop   = w_rd && (w_reg == REG_DATA) && !w_empty;
    assign w_push  = smp_valid && r_en && (!w_full || w_pop) && !w_flush;
    assign w_drop  = smp_valid && r_en && w_full && !w_pop && !w_flush;

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (wb_clk_i),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (smp_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    // Read-data mux reflecting state before the ack edge
    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_CTRL:   w_rdata = {30'b0, 1'b0, r_en};
            REG_STATUS: w_rdata = pack_status(ST_LEVEL_W'(w_level), w_empty, w_full, r_ovf, r_udf);
            REG_DATA:   w_rdata = w_empty ? 32'h0 : w_mem_rdata;
            REG_OVF:    w_rdata = 32'(r_ovf_cnt);
            default:    w_rdata = '0;
        endcase
    end

    // FIFO pointers; flush wins over a same-edge push
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Control and sticky status; a new event beats a same-edge clear of its flag
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_en      <= 1'b0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            r_ovf_cnt <= '0;
        end else begin
            if (w_wr && (w_reg == REG_CTRL))
                r_en <= wb_dat_i[CTRL_EN_BIT];

            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_wr && (w_reg == REG_STATUS) && wb_dat_i[ST_OVF_BIT])
                r_ovf <= 1'b0;

            if (w_rd && (w_reg == REG_DATA) && w_empty)
                r_udf <= 1'b1;
            else if (w_wr && (w_reg == REG_STATUS) && wb_dat_i[ST_UDF_BIT])
                r_udf <= 1'b0;

            if (w_wr && (w_reg == REG_OVF))
                r_ovf_cnt <= '0;
            else if (w_drop)
                r_ovf_cnt <= sat_inc(r_ovf_cnt);
        end
    end

    // Registered single-cycle ack and read data, zero outside ack
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_start;
            r_dat <= w_rd ? w_rdata : 32'h0;
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_sample_fifo.sv
// Directed bench for wb_sample_fifo: a table of register/sample steps with
// hand-computed read values, plus hand-written multi-cycle sequences.
module tb_wb_sample_fifo;

    localparam int DEPTH = 64;
    localparam int OVF_W = 16;

    localparam int OP_R = 0;
    localparam int OP_W = 1;
    localparam int OP_P = 2;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic [31:0] dat_o;
    logic        ack;
    logic        rty;
    logic        smp_valid;
    logic [31:0] smp_data;

    int n_checks;
    int n_errors;

    typedef struct {
        int          op;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[$];

    wb_sample_fifo #(
        .DEPTH (DEPTH),
        .OVF_W (OVF_W)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat_i),
        .wb_sel_i  (sel),
        .wb_we_i   (we),
        .wb_stb_i  (stb),
        .wb_cyc_i  (cyc),
        .wb_dat_o  (dat_o),
        .wb_ack_o  (ack),
        .wb_rty_o  (rty),
        .smp_valid (smp_valid),
        .smp_data  (smp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One bus access starting at edge+1; ack must come after exactly one edge
    task automatic bus(input bit w, input logic [3:0] a, input logic [31:0] d,
                       output logic [31:0] rd);
        int n;
        n     = 0;
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        adr   = {28'h0, a};
        dat_i = d;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 4);
        rd  = dat_o;
        chk("ack_latency", 32'(n), 32'd1);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        @(posedge clk); #1;
        chk("ack_drop", {31'b0, ack}, 32'd0);
    endtask

    task automatic push1(input logic [31:0] d);
        smp_valid = 1'b1;
        smp_data  = d;
        @(posedge clk); #1;
        smp_valid = 1'b0;
    endtask

    // Sample push and DATA pop sharing one edge
    task automatic pop_push(input logic [31:0] d, output logic [31:0] rd);
        smp_valid = 1'b1;
        smp_data  = d;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8;
        @(posedge clk); #1;
        smp_valid = 1'b0;
        chk("pp_ack", {31'b0, ack}, 32'd1);
        rd  = dat_o;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        saw_ack;
        int          k;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; adr = '0; dat_i = '0; sel = 4'hF; we = 1'b0;
        stb = 1'b0; cyc = 1'b0; smp_valid = 1'b0; smp_data = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rty_zero", {31'b0, rty}, 32'd0);
        rst = 1'b0;

        // Basic register flow, underflow, flush and enable gating
        vt.push_back('{OP_R, 4'h4, 32'h0,        32'h0001_0000, "st_reset"});
        vt.push_back('{OP_R, 4'h0, 32'h0,        32'h0000_0000, "ctrl_reset"});
        vt.push_back('{OP_R, 4'hC, 32'h0,        32'h0000_0000, "ovf_reset"});
        vt.push_back('{OP_W, 4'h0, 32'h1,        32'h0,         "wr_en"});
        vt.push_back('{OP_P, 4'h0, 32'h11,       32'h0,         "p11"});
        vt.push_back('{OP_P, 4'h0, 32'h22,       32'h0,         "p22"});
        vt.push_back('{OP_P, 4'h0, 32'h33,       32'h0,         "p33"});
        vt.push_back('{OP_R, 4'h4, 32'h0,        32'h0000_0003, "st_lvl3"});
        vt.push_back('{OP_R, 4'h0, 32'h0,        32'h0000_0001, "ctrl_en"});
        vt.push_back('{OP_R, 4'h8, 32'h0,        32'h0000_0011, "rd_11"});
        vt.push_back('{OP_R, 4'h8, 32'h0,        32'h0000_0022, "rd_22"});
        vt.push_back('{OP_R, 4'h8, 32'h0,        32'h0000_0033, "rd_33"});
        vt.push_back('{OP_R, 4'h4, 32'h0,        32'h0001_0000, "st_empty"});
        vt.push_back('{OP_R, 4'h8, 32'h0,        32'h0000_0000, "rd_udf"});
        vt.push_back('{OP_R, 4'h4, 32'h0,        32'h0009_0000, "st_udf"});
        vt.push_back('{OP_W, 4'h4, 32'h0008_0000, 32'h0,        "clr_udf"});
        vt.push_back('{OP_R, 4'h4, 32'h0,        32'h0001_0000, "st_udf_clr"});
        vt.push_back('{OP_W, 4'h8, 32'hDEAD,     32'h0,         "wr_data"});
        vt.push_back('{OP_R, 4'h4, 32'h0,        32'h0001_0000, "st_wr_data"});
        vt.push_back('{OP_P, 4'h0, 32'hAA,       32'h0,         "pAA"});
        vt.push_back('{OP_P, 4'h0, 32'hBB,       32'h0,         "pBB"});
        vt.push_back('{OP_R, 4'h4, 32'h0,        32'h0000_0002, "st_lvl2"});
        vt.push_back('{OP_W, 4'h0, 32'h3,        32'h0,         "flush"});
        vt.push_back('{OP_R, 4'h4, 32'h0,        32'h0001_0000, "st_flushed"});
        vt.push_back('{OP_R, 4'h0, 32'h0,        32'h0000_0001, "ctrl_flush0"});
        vt.push_back('{OP_W, 4'h0, 32'h0,        32'h0,         "dis"});
        vt.push_back('{OP_P, 4'h0, 32'h55,       32'h0,         "p55_off"});
        vt.push_back('{OP_R, 4'h4, 32'h0,        32'h0001_0000, "st_dis"});
        vt.push_back('{OP_R, 4'hC, 32'h0,        32'h0000_0000, "ovf_dis"});
        vt.push_back('{OP_W, 4'h0, 32'h1,        32'h0,         "reen"});
        vt.push_back('{OP_P, 4'h0, 32'h77,       32'h0,         "p77"});
        vt.push_back('{OP_R, 4'h8, 32'h0,        32'h0000_0077, "rd_77"});

        foreach (vt[i]) begin
            case (vt[i].op)
                OP_R: begin
                    bus(1'b0, vt[i].a, 32'h0, rd);
                    chk(vt[i].name, rd, vt[i].exp);
                end
                OP_W: bus(1'b1, vt[i].a, vt[i].d, rd);
                default: push1(vt[i].d);
            endcase
        end

        // Overflow: DEPTH+5 back-to-back samples
        smp_valid = 1'b1;
        for (int i = 0; i < DEPTH + 5; i++) begin
            smp_data = 32'h1000 + 32'(i);
            @(posedge clk); #1;
        end
        smp_valid = 1'b0;
        bus(1'b0, 4'h4, 32'h0, rd);
        chk("st_full_ovf", rd, 32'h0006_0040);
        bus(1'b0, 4'hC, 32'h0, rd);
        chk("ovf_cnt5", rd, 32'd5);

        // Push+pop on the same edge at full, across pointer wrap
        for (int i = 0; i < 4; i++) begin
            pop_push(32'h2000 + 32'(i), rd);
            chk("pp_data", rd, 32'h1000 + 32'(i));
            if (i == 0) begin
                bus(1'b0, 4'h4, 32'h0, rd);
                chk("pp_st_full", rd, 32'h0006_0040);
                bus(1'b0, 4'hC, 32'h0, rd);
                chk("pp_ovf_same", rd, 32'd5);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            bus(1'b0, 4'h8, 32'h0, rd);
            chk("drain", rd, (i < DEPTH - 4) ? 32'h1004 + 32'(i) : 32'h2000 + 32'(i - (DEPTH - 4)));
        end
        bus(1'b0, 4'h4, 32'h0, rd);
        chk("st_drained", rd, 32'h0005_0000);

        // Held strobe on DATA for 6 cycles
        for (int i = 0; i < 4; i++) push1(32'h31 + 32'(i));
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("held_ack", {31'b0, ack}, (c % 2 == 0) ? 32'd1 : 32'd0);
            if (ack) begin
                chk("held_data", dat_o, 32'h31 + 32'(k));
                k++;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        bus(1'b0, 4'h4, 32'h0, rd);
        chk("held_st", rd, 32'h0004_0001);
        bus(1'b0, 4'h8, 32'h0, rd);
        chk("held_last", rd, 32'h34);

        // Reset in the middle of an access with level 10
        for (int i = 0; i < 10; i++) push1(32'h500 + 32'(i));
        bus(1'b0, 4'h4, 32'h0, rd);
        chk("st_lvl10", rd, 32'h0004_000A);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8;
        #3;
        rst = 1'b1;
        saw_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (ack) saw_ack = 1'b1;
        end
        chk("rst_mid_ack", {31'b0, saw_ack}, 32'd0);
        chk("rst_mid_dat", dat_o, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        rst = 1'b0;
        bus(1'b0, 4'h4, 32'h0, rd);
        chk("post_rst_st", rd, 32'h0001_0000);
        bus(1'b0, 4'h0, 32'h0, rd);
        chk("post_rst_ctrl", rd, 32'h0);
        bus(1'b0, 4'hC, 32'h0, rd);
        chk("post_rst_ovf", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_sample_fifo.md
WB_SAMPLE_FIFO -- requirements
Module: wb_sample_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 64, FIFO depth in 32-bit words (power of two, 4..1024).
REQ-002 SHALL have parameter OVF_W, default 16, overflow counter width (1..32).
REQ-003 SHALL have port wb_clk_i  in  1  single clock for all logic.
REQ-004 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wb_adr_i  in  32  byte address; only bits [3:2] decoded.
REQ-006 SHALL have port wb_dat_i  in  32  write data.
REQ-007 SHALL have port wb_sel_i  in  4  byte selects; ignored, full-word access only.
REQ-008 SHALL have ports wb_we_i, wb_stb_i, wb_cyc_i  in  1 each  Wishbone classic strobes.
REQ-009 SHALL have port wb_dat_o  out  32  read data, valid while wb_ack_o=1, else 0.
REQ-010 SHALL have port wb_ack_o  out  1  single-cycle acknowledge.
REQ-011 SHALL have port wb_rty_o  out  1  tied 0.
REQ-012 SHALL have ports smp_valid  in  1  and smp_data  in  32: capture stream, no backpressure.

Function
REQ-013 Register map SHALL be: 0x0 CTRL (RW: bit0 EN; bit1 FLUSH, write-1 self-clearing, reads 0); 0x4 STATUS (RO); 0x8 DATA (RO, pop); 0xC OVF_CNT (RO, write any value clears).
REQ-014 STATUS SHALL be: [10:0] level, [16] empty, [17] full, [18] ovf sticky, [19] udf sticky; writing STATUS with bit18/bit19 set SHALL clear that sticky bit.
REQ-015 Access SHALL complete with wb_ack_o=1 exactly one cycle after the first cycle of cyc&stb; ack SHALL drop the next cycle, even if stb is held.
REQ-016 A held stb after ack SHALL be treated as a new access only after one idle ack-low cycle; each access SHALL cause at most one register side effect (one pop, one write).
REQ-017 smp_valid=1 with EN=1 and not full SHALL push smp_data the same edge; EN=0 SHALL ignore samples without counting.
REQ-018 smp_valid=1 with EN=1 and full SHALL drop the sample, set ovf, and increment OVF_CNT, saturating at all ones.
REQ-019 A DATA read when non-empty SHALL return the oldest word and pop it on the ack edge.
REQ-020 A DATA read when empty SHALL return 0x0000_0000, not pop, and set udf.
REQ-021 A push and a pop on the same edge SHALL both take effect, level unchanged; at full, a pop SHALL free the slot, so the simultaneous push SHALL be accepted without overflow.
REQ-022 FLUSH SHALL zero pointers and level on the write ack edge and SHALL take priority over a same-edge push; ovf, udf and OVF_CNT SHALL be retained.
REQ-023 Pointers SHALL be log2(DEPTH)+1 bits with wrap bit; full SHALL be asserted when the addresses are equal and the wrap bits differ.
REQ-024 Writes to DATA SHALL be acknowledged and ignored; reads of CTRL SHALL return {30'b0, 1'b0, EN}.

Reset
REQ-025 Asserting wb_rst_i SHALL immediately clear: EN, pointers, level, ovf, udf, OVF_CNT, wb_ack_o, and wb_dat_o (all 0); empty=1.
REQ-026 Reset mid-access SHALL abort the access with no ack; storage RAM contents need not reset.
REQ-027 The first access SHALL be accepted on the first edge after reset deassertion.

Structure
REQ-028 Shared package pawc_pkg SHALL hold register offset constants, STATUS bit-position constants and CTRL bit constants.
REQ-029 Storage SHALL be a sub-module sync_fifo_mem (1 write port, 1 read port, DEPTH x 32); the read-data path SHALL still meet REQ-015 latency.
REQ-030 The block SHALL be attachable as a slave on the existing wb_intercon without glue.

Verification
REQ-031 Reset, then write CTRL=1, push 0x11,0x22,0x33 -> STATUS level=3; DATA reads return 0x11, 0x22, 0x33, then level=0, empty=1.
REQ-032 EN=1, push DEPTH+5 samples without reads -> full=1, ovf=1, OVF_CNT=5; first DATA read returns sample 0.
REQ-033 Read DATA when empty -> read returns 0x0, udf=1, level stays 0; write STATUS=0x0008_0000 -> udf=0.
REQ-034 At full, a same-cycle push and DATA pop -> level stays DEPTH, OVF_CNT unchanged, order preserved across pointer wrap.
REQ-035 Hold stb/cyc for 6 cycles on DATA -> ack pulses separated by idle cycles, one pop per ack.
REQ-036 Assert wb_rst_i mid-access with level=10 -> ack never rises; after release, level=0, EN=0, OVF_CNT=0.
